clk_gate_ctrl: RTL

CLK_GATE_CTRL -- requirements
Module: clk_gate_ctrl

---
 rtl/clk_gate_ctrl.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/clk_gate_ctrl.sv
// clk_gate_ctrl
//   Per-unit clock-gate enable controller. Each unit runs a small FSM
//   (OFF -> WAKE -> ON -> COOL -> OFF). It turns its clock-gate enable on
//   when a requester or a software override needs the unit. Once the clock
//   has settled it reports ready. It gates the clock off again after a
//   programmable number of idle cycles.
//
// Parameters
//   NumUnits   : number of independently gated units (1..32)
//   IdleCycles : idle cycles spent in COOL before gating off (1..65535)
//   WakeCycles : cycles from enable rise to ready (1..255)
//
// Ports
//   clk_i        in   1         clock, all state updates on the rising edge
//   rst_i        in   1         synchronous active-high reset
//   test_en_i    in   1         scan/test mode, forces every enable on
//   force_on_i   in   NumUnits  per-unit software keep-running override
//   req_valid_i  in   NumUnits  per-unit requester needs the clock
//   busy_i       in   NumUnits  per-unit activity report from the gated unit
//   req_ready_o  out  NumUnits  unit clock is running and stable
//   en_o         out  NumUnits  enable to each unit's clock-gate cell
//   all_off_o    out  1         every unit FSM is in OFF
module clk_gate_ctrl #(
  parameter int NumUnits   = 4,
  parameter int IdleCycles = 16,
  parameter int WakeCycles = 2
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                test_en_i,
  input  logic [NumUnits-1:0] force_on_i,
  input  logic [NumUnits-1:0] req_valid_i,
  input  logic [NumUnits-1:0] busy_i,
  output logic [NumUnits-1:0] req_ready_o,
  output logic [NumUnits-1:0] en_o,
  output logic                all_off_o
);

  // The counter only ever holds load values of the form N-1.
  // Its width therefore covers 0..max(IdleCycles, WakeCycles)-1.
  localparam int MaxCnt = (IdleCycles > WakeCycles) ? IdleCycles : WakeCycles;
  localparam int CntW   = (MaxCnt > 1) ? $clog2(MaxCnt) : 1;
  localparam logic [CntW-1:0] WakeLoad = CntW'(WakeCycles - 1);
  localparam logic [CntW-1:0] IdleLoad = CntW'(IdleCycles - 1);

  typedef enum logic [1:0] {
    ST_OFF  = 2'd0,
    ST_WAKE = 2'd1,
    ST_ON   = 2'd2,
    ST_COOL = 2'd3
  } state_e;

  state_e              state_q [NumUnits];
  state_e              state_d [NumUnits];
  logic [CntW-1:0]     cnt_q   [NumUnits];
  logic [CntW-1:0]     cnt_d   [NumUnits];
  logic [NumUnits-1:0] run_q;
  logic [NumUnits-1:0] run_d;
  logic [NumUnits-1:0] ready_q;
  logic [NumUnits-1:0] ready_d;
  logic                all_off_q;
  logic                all_off_d;
  logic [NumUnits-1:0] act_s;
  logic [NumUnits-1:0] wake_s;

  // Next-state and counter logic for every unit FSM.
  // The outputs are decoded here from the next state, so each output flop
  // reflects the state held in the same cycle.
  always_comb begin
    act_s     = req_valid_i | busy_i | force_on_i;
    // busy_i alone keeps a running unit alive but never wakes a gated one.
    wake_s    = req_valid_i | force_on_i;
    run_d     = '0;
    ready_d   = '0;
    for (int i = 0; i < NumUnits; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      case (state_q[i])
        ST_OFF: begin
          if (wake_s[i]) begin
            state_d[i] = ST_WAKE;
            cnt_d[i]   = WakeLoad;
          end else begin
            state_d[i] = ST_OFF;
          end
        end
        ST_WAKE: begin
          // A withdrawn request does not abort the wake-up.
          if (cnt_q[i] == '0) begin
            state_d[i] = ST_ON;
          end else begin
            cnt_d[i] = cnt_q[i] - CntW'(1);
          end
        end
        ST_ON: begin
          if (!act_s[i]) begin
            state_d[i] = ST_COOL;
            cnt_d[i]   = IdleLoad;
          end else begin
            state_d[i] = ST_ON;
          end
        end
        ST_COOL: begin
          // Activity beats expiry. The counter is left untouched on re-entry
          // to ON because ON reloads it on its next idle cycle.
          if (act_s[i]) begin
            state_d[i] = ST_ON;
          end else if (cnt_q[i] == '0) begin
            state_d[i] = ST_OFF;
          end else begin
            cnt_d[i] = cnt_q[i] - CntW'(1);
          end
        end
        default: begin
          state_d[i] = ST_OFF;
          cnt_d[i]   = '0;
        end
      endcase
      run_d[i]   = (state_d[i] != ST_OFF);
      ready_d[i] = (state_d[i] == ST_ON) || (state_d[i] == ST_COOL);
    end
    all_off_d = ~|run_d;
  end

  // State, counter and registered output flops with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < NumUnits; i++) begin
        state_q[i] <= ST_OFF;
        cnt_q[i]   <= '0;
      end
      run_q     <= '0;
      ready_q   <= '0;
      all_off_q <= 1'b1;
    end else begin
      for (int i = 0; i < NumUnits; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
      run_q     <= run_d;
      ready_q   <= ready_d;
      all_off_q <= all_off_d;
    end
  end

  // test_en_i is ORed in after the flops so scan mode gets its clocks
  // immediately, without disturbing any FSM state.
  assign en_o        = run_q | {NumUnits{test_en_i}};
  assign req_ready_o = ready_q;
  assign all_off_o   = all_off_q;

endmodule
